// File: rtl/wb_pkg.sv
// Shared encodings for the write-back controller: data-mux selects, FSM states,
// and the ALU starvation threshold used when WB_STARVE_GUARD_EN is defined.
package wb_pkg;

    typedef enum logic [1:0] {
        SEL_ALU = 2'b00,
        SEL_MEM = 2'b01,
        SEL_PC  = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_STALL = 2'b10
    } wb_state_e;

    localparam int unsigned STARVE_CNT_W = 3;
    localparam logic [STARVE_CNT_W-1:0] STARVE_THRESH = 3'd4;

endpackage

// File: rtl/wb_arbiter.sv
// Fixed-priority select mem > link > alu; with WB_STARVE_GUARD_EN an ALU request
// left waiting STARVE_THRESH consecutive cycles overrides every other source.
module wb_arbiter
    import wb_pkg::*;
(
`ifdef WB_STARVE_GUARD_EN
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    grant_en_i,
`endif
    input  logic    alu_vld_i,
    input  logic    mem_vld_i,
    input  logic    link_vld_i,
    output logic    alu_win_o,
    output logic    mem_win_o,
    output logic    link_win_o,
    output wb_sel_e sel_o
);

    logic starve;

`ifdef WB_STARVE_GUARD_EN
    logic [STARVE_CNT_W-1:0] starve_cnt_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_d;

    // Counts only real losses: cycles where ALU is pending but not actually granted.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!alu_vld_i || (grant_en_i && alu_win_o)) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != '1) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve = (starve_cnt_q >= STARVE_THRESH);
`else
    assign starve = 1'b0;
`endif

    always_comb begin
        alu_win_o  = 1'b0;
        mem_win_o  = 1'b0;
        link_win_o = 1'b0;
        sel_o      = SEL_ALU;
        if (starve && alu_vld_i) begin
            alu_win_o = 1'b1;
            sel_o     = SEL_ALU;
        end else if (mem_vld_i) begin
            mem_win_o = 1'b1;
            sel_o     = SEL_MEM;
        end else if (link_vld_i) begin
            link_win_o = 1'b1;
            sel_o      = SEL_PC;
        end else if (alu_vld_i) begin
            alu_win_o = 1'b1;
            sel_o     = SEL_ALU;
        end
    end

endmodule

// File: rtl/writeback_ctrl.sv
// Write-back arbiter/FSM: one grant per cycle, registered mux select/address/enable one cycle later.
// Optional ALU starvation guard compiled in with WB_STARVE_GUARD_EN.
module writeback_ctrl
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_valid,
    input  logic [4:0] alu_rd,
    output logic       alu_ready,
    input  logic       mem_valid,
    input  logic [4:0] mem_rd,
    output logic       mem_ready,
    input  logic       link_valid,
    input  logic [4:0] link_rd,
    output logic       link_ready,
    input  logic       wb_stall,
    output logic [1:0] PCMemReg,
    output logic       reg_we,
    output logic [4:0] wr_addr,
    output logic       busy
);

    wb_state_e  state_q;
    logic       reg_we_q;
    wb_sel_e    sel_q;
    logic [4:0] addr_q;

    logic       grant_en;
    logic       any_grant;
    logic       alu_win;
    logic       mem_win;
    logic       link_win;
    wb_sel_e    win_sel;
    logic [4:0] win_rd;

    // The cycle after a stall releases is still spent in STALL, so no grant there.
    assign grant_en = !rst && !wb_stall && (state_q != ST_STALL);

    wb_arbiter u_arbiter (
`ifdef WB_STARVE_GUARD_EN
        .clk_i      (clk),
        .rst_i      (rst),
        .grant_en_i (grant_en),
`endif
        .alu_vld_i  (alu_valid),
        .mem_vld_i  (mem_valid),
        .link_vld_i (link_valid),
        .alu_win_o  (alu_win),
        .mem_win_o  (mem_win),
        .link_win_o (link_win),
        .sel_o      (win_sel)
    );

    assign alu_ready  = grant_en && alu_win;
    assign mem_ready  = grant_en && mem_win;
    assign link_ready = grant_en && link_win;
    assign any_grant  = alu_ready || mem_ready || link_ready;

    always_comb begin
        case (win_sel)
            SEL_MEM: win_rd = mem_rd;
            SEL_PC:  win_rd = link_rd;
            default: win_rd = alu_rd;
        endcase
    end

    assign busy = (alu_valid && !alu_ready) || (mem_valid && !mem_ready) ||
                  (link_valid && !link_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            reg_we_q <= 1'b0;
            sel_q    <= SEL_ALU;
            addr_q   <= '0;
        end else if (wb_stall) begin
            state_q  <= ST_STALL;
            reg_we_q <= 1'b0;
        end else begin
            case (state_q)
                ST_STALL: begin
                    state_q  <= ST_IDLE;
                    reg_we_q <= 1'b0;
                end
                default: begin
                    if (any_grant) begin
                        state_q  <= ST_WRITE;
                        // x0 is hardwired: accept the request but suppress the write.
                        reg_we_q <= (win_rd != 5'd0);
                        sel_q    <= win_sel;
                        addr_q   <= win_rd;
                    end else begin
                        state_q  <= ST_IDLE;
                        reg_we_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign PCMemReg = sel_q;
    assign reg_we   = reg_we_q;
    assign wr_addr  = addr_q;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed-vector bench for writeback_ctrl; guard-dependent expectations follow WB_STARVE_GUARD_EN.
module tb_writeback_ctrl;

    logic       clk;
    logic       rst;
    logic       alu_valid;
    logic [4:0] alu_rd;
    logic       alu_ready;
    logic       mem_valid;
    logic [4:0] mem_rd;
    logic       mem_ready;
    logic       link_valid;
    logic [4:0] link_rd;
    logic       link_ready;
    logic       wb_stall;
    logic [1:0] PCMemReg;
    logic       reg_we;
    logic [4:0] wr_addr;
    logic       busy;

    int vec_cnt;
    int err_cnt;

    writeback_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_ready  (mem_ready),
        .link_valid (link_valid),
        .link_rd    (link_rd),
        .link_ready (link_ready),
        .wb_stall   (wb_stall),
        .PCMemReg   (PCMemReg),
        .reg_we     (reg_we),
        .wr_addr    (wr_addr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1; link_valid = 1'b1;
        alu_rd = 5'd1; mem_rd = 5'd2; link_rd = 5'd3; wb_stall = 1'b0;
        tick; tick;
        vec_cnt++; if (alu_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_alu_ready: got %b want 0", alu_ready); end
        vec_cnt++; if (mem_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
        vec_cnt++; if (link_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_link_ready: got %b want 0", link_ready); end
        vec_cnt++; if (reg_we !== 1'b0) begin err_cnt++; $display("FAIL reset_reg_we: got %b want 0", reg_we); end
        vec_cnt++; if (PCMemReg !== 2'b00) begin err_cnt++; $display("FAIL reset_pcmemreg: got %b want 00", PCMemReg); end
        vec_cnt++; if (wr_addr !== 5'd0) begin err_cnt++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL reset_busy: got %b want 1", busy); end
        alu_valid = 1'b0; mem_valid = 1'b0; link_valid = 1'b0;
        rst = 1'b0;
        tick;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_alu_single;
        alu_valid = 1'b1; alu_rd = 5'd5;
        #1;
        vec_cnt++; if (alu_ready !== 1'b1) begin err_cnt++; $display("FAIL alu_single_ready: got %b want 1", alu_ready); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL alu_single_busy: got %b want 0", busy); end
        tick;
        alu_valid = 1'b0;
        vec_cnt++; if (reg_we !== 1'b1) begin err_cnt++; $display("FAIL alu_single_we: got %b want 1", reg_we); end
        vec_cnt++; if (wr_addr !== 5'd5) begin err_cnt++; $display("FAIL alu_single_addr: got %0d want 5", wr_addr); end
        vec_cnt++; if (PCMemReg !== 2'b00) begin err_cnt++; $display("FAIL alu_single_sel: got %b want 00", PCMemReg); end
        tick;
        vec_cnt++; if (reg_we !== 1'b0) begin err_cnt++; $display("FAIL alu_single_we_pulse: got %b want 0", reg_we); end
        vec_cnt++; if (wr_addr !== 5'd5) begin err_cnt++; $display("FAIL alu_single_addr_hold: got %0d want 5", wr_addr); end
    endtask

    task automatic test_priority;
        logic [4:0] exp_addr [3];
        logic [1:0] exp_sel  [3];
        exp_addr[0] = 5'd3;  exp_sel[0] = 2'b01;
        exp_addr[1] = 5'd31; exp_sel[1] = 2'b10;
        exp_addr[2] = 5'd7;  exp_sel[2] = 2'b00;
        mem_valid = 1'b1; mem_rd = 5'd3;
        link_valid = 1'b1; link_rd = 5'd31;
        alu_valid = 1'b1; alu_rd = 5'd7;
        #1;
        vec_cnt++; if ({mem_ready, link_ready, alu_ready} !== 3'b100) begin err_cnt++; $display("FAIL prio_readies: got %b want 100", {mem_ready, link_ready, alu_ready}); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL prio_busy: got %b want 1", busy); end
        for (int i = 0; i < 3; i++) begin
            tick;
            if (i == 0) mem_valid = 1'b0;
            if (i == 1) link_valid = 1'b0;
            if (i == 2) alu_valid = 1'b0;
            vec_cnt++; if (reg_we !== 1'b1) begin err_cnt++; $display("FAIL prio_we[%0d]: got %b want 1", i, reg_we); end
            vec_cnt++; if (wr_addr !== exp_addr[i]) begin err_cnt++; $display("FAIL prio_addr[%0d]: got %0d want %0d", i, wr_addr, exp_addr[i]); end
            vec_cnt++; if (PCMemReg !== exp_sel[i]) begin err_cnt++; $display("FAIL prio_sel[%0d]: got %b want %b", i, PCMemReg, exp_sel[i]); end
        end
        tick;
        vec_cnt++; if (reg_we !== 1'b0) begin err_cnt++; $display("FAIL prio_we_end: got %b want 0", reg_we); end
    endtask

    task automatic test_back_to_back;
        alu_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            alu_rd = 5'(i + 10);
            tick;
            vec_cnt++; if ((reg_we !== 1'b1) || (wr_addr !== 5'(i + 10))) begin err_cnt++; $display("FAIL b2b[%0d]: got we=%b addr=%0d want we=1 addr=%0d", i, reg_we, wr_addr, i + 10); end
        end
        alu_valid = 1'b0;
        tick;
    endtask

    task automatic test_rd_zero;
        alu_valid = 1'b1; alu_rd = 5'd0;
        #1;
        vec_cnt++; if (alu_ready !== 1'b1) begin err_cnt++; $display("FAIL rd0_ready: got %b want 1", alu_ready); end
        tick;
        alu_valid = 1'b0;
        vec_cnt++; if (reg_we !== 1'b0) begin err_cnt++; $display("FAIL rd0_we: got %b want 0", reg_we); end
        vec_cnt++; if (wr_addr !== 5'd0) begin err_cnt++; $display("FAIL rd0_addr: got %0d want 0", wr_addr); end
        tick;
    endtask

    task automatic test_stall;
        wb_stall = 1'b1; mem_valid = 1'b1; mem_rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++; if (mem_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_ready[%0d]: got %b want 0", i, mem_ready); end
            tick;
            vec_cnt++; if (reg_we !== 1'b0) begin err_cnt++; $display("FAIL stall_we[%0d]: got %b want 0", i, reg_we); end
            vec_cnt++; if (wr_addr !== 5'd0) begin err_cnt++; $display("FAIL stall_addr_hold[%0d]: got %0d want 0", i, wr_addr); end
        end
        wb_stall = 1'b0;
        #1;
        vec_cnt++; if (mem_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_release_ready: got %b want 0", mem_ready); end
        tick;
        vec_cnt++; if (reg_we !== 1'b0) begin err_cnt++; $display("FAIL stall_release_we: got %b want 0", reg_we); end
        #1;
        vec_cnt++; if (mem_ready !== 1'b1) begin err_cnt++; $display("FAIL stall_after_ready: got %b want 1", mem_ready); end
        tick;
        mem_valid = 1'b0;
        vec_cnt++; if ((reg_we !== 1'b1) || (wr_addr !== 5'd9) || (PCMemReg !== 2'b01)) begin err_cnt++; $display("FAIL stall_write: got we=%b addr=%0d sel=%b want we=1 addr=9 sel=01", reg_we, wr_addr, PCMemReg); end
        tick;
    endtask

    task automatic test_starve;
        logic exp_alu;
        mem_valid = 1'b1; mem_rd = 5'd4;
        alu_valid = 1'b1; alu_rd = 5'd6;
        for (int c = 1; c <= 6; c++) begin
            #1;
`ifdef WB_STARVE_GUARD_EN
            exp_alu = (c == 5);
`else
            exp_alu = 1'b0;
`endif
            vec_cnt++; if (alu_ready !== exp_alu) begin err_cnt++; $display("FAIL starve_alu_ready[%0d]: got %b want %b", c, alu_ready, exp_alu); end
            vec_cnt++; if (mem_ready !== !exp_alu) begin err_cnt++; $display("FAIL starve_mem_ready[%0d]: got %b want %b", c, mem_ready, !exp_alu); end
            tick;
            if (exp_alu) alu_valid = 1'b0;
        end
        mem_valid = 1'b0;
        #1;
`ifdef WB_STARVE_GUARD_EN
        exp_alu = 1'b0;
`else
        exp_alu = 1'b1;
`endif
        vec_cnt++; if (alu_ready !== exp_alu) begin err_cnt++; $display("FAIL starve_alu_after: got %b want %b", alu_ready, exp_alu); end
        tick;
        alu_valid = 1'b0;
        tick;
    endtask

    task automatic test_reset_on_grant;
        mem_valid = 1'b1; mem_rd = 5'd12;
        tick;
        mem_valid = 1'b0;
        vec_cnt++; if ((reg_we !== 1'b1) || (wr_addr !== 5'd12)) begin err_cnt++; $display("FAIL rstg_setup: got we=%b addr=%0d want we=1 addr=12", reg_we, wr_addr); end
        link_valid = 1'b1; link_rd = 5'd20;
        #1;
        vec_cnt++; if (link_ready !== 1'b1) begin err_cnt++; $display("FAIL rstg_pre_ready: got %b want 1", link_ready); end
        rst = 1'b1;
        #1;
        vec_cnt++; if (link_ready !== 1'b0) begin err_cnt++; $display("FAIL rstg_ready: got %b want 0", link_ready); end
        tick;
        rst = 1'b0; link_valid = 1'b0;
        vec_cnt++; if (reg_we !== 1'b0) begin err_cnt++; $display("FAIL rstg_we: got %b want 0", reg_we); end
        vec_cnt++; if (PCMemReg !== 2'b00) begin err_cnt++; $display("FAIL rstg_sel: got %b want 00", PCMemReg); end
        vec_cnt++; if (wr_addr !== 5'd0) begin err_cnt++; $display("FAIL rstg_addr: got %0d want 0", wr_addr); end
        tick;
        vec_cnt++; if (reg_we !== 1'b0) begin err_cnt++; $display("FAIL rstg_we_after: got %b want 0", reg_we); end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset;
        test_alu_single;
        test_priority;
        test_back_to_back;
        test_rd_zero;
        test_stall;
        test_starve;
        test_reset_on_grant;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
